// File: rtl/mem_port_arbiter_pkg.sv
// State codes, the control unit's MemRead/MemWrite encodings, and the request legality helpers
// shared by the memory-port arbiter and its lane aligner.
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_BUSY = 2'd1,
    ARB_RESP = 2'd2
  } arb_state_e;

  localparam logic [2:0] MEMREAD_NONE = 3'd0;
  localparam logic [2:0] MEMREAD_LB   = 3'd1;
  localparam logic [2:0] MEMREAD_LH   = 3'd2;
  localparam logic [2:0] MEMREAD_LW   = 3'd3;
  localparam logic [2:0] MEMREAD_LBU  = 3'd4;
  localparam logic [2:0] MEMREAD_LHU  = 3'd5;

  localparam logic [1:0] MEMWRITE_NONE = 2'd0;
  localparam logic [1:0] MEMWRITE_SB   = 2'd1;
  localparam logic [1:0] MEMWRITE_SH   = 2'd2;
  localparam logic [1:0] MEMWRITE_SW   = 2'd3;

  function automatic logic op_illegal(input logic [2:0] rd, input logic [1:0] wr);
    return (rd > MEMREAD_LHU) || ((rd != MEMREAD_NONE) && (wr != MEMWRITE_NONE));
  endfunction

  function automatic logic op_misaligned(input logic [2:0] rd, input logic [1:0] wr,
                                         input logic [1:0] off);
    logic mis;
    mis = 1'b0;
    if ((rd == MEMREAD_LH) || (rd == MEMREAD_LHU) || (wr == MEMWRITE_SH)) mis = off[0];
    if ((rd == MEMREAD_LW) || (wr == MEMWRITE_SW)) mis = (off != 2'b00);
    return mis;
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Combinational byte-lane logic: extracts/extends load data from a memory word and
// builds store byte enables plus lane-replicated write data.
module mem_lane_align
  import mem_port_arbiter_pkg::*;
(
  input  logic [2:0]  ld_op_i,
  input  logic [1:0]  ld_off_i,
  input  logic [31:0] ld_word_i,
  output logic [31:0] ld_data_o,
  input  logic [1:0]  st_op_i,
  input  logic [1:0]  st_off_i,
  input  logic [31:0] st_data_i,
  output logic [3:0]  st_be_o,
  output logic [31:0] st_wdata_o
);

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  always_comb begin
    ld_byte = ld_word_i[7:0];
    case (ld_off_i)
      2'd1:    ld_byte = ld_word_i[15:8];
      2'd2:    ld_byte = ld_word_i[23:16];
      2'd3:    ld_byte = ld_word_i[31:24];
      default: ld_byte = ld_word_i[7:0];
    endcase
    ld_half = ld_off_i[1] ? ld_word_i[31:16] : ld_word_i[15:0];
  end

  always_comb begin
    ld_data_o = '0;
    case (ld_op_i)
      MEMREAD_LB:  ld_data_o = {{24{ld_byte[7]}}, ld_byte};
      MEMREAD_LBU: ld_data_o = {24'h0, ld_byte};
      MEMREAD_LH:  ld_data_o = {{16{ld_half[15]}}, ld_half};
      MEMREAD_LHU: ld_data_o = {16'h0, ld_half};
      MEMREAD_LW:  ld_data_o = ld_word_i;
      default:     ld_data_o = '0;
    endcase
  end

  always_comb begin
    st_be_o    = 4'h0;
    st_wdata_o = '0;
    case (st_op_i)
      MEMWRITE_SB: begin
        st_be_o    = 4'(4'b0001 << st_off_i);
        st_wdata_o = {4{st_data_i[7:0]}};
      end
      MEMWRITE_SH: begin
        st_be_o    = st_off_i[1] ? 4'hC : 4'h3;
        st_wdata_o = {2{st_data_i[15:0]}};
      end
      MEMWRITE_SW: begin
        st_be_o    = 4'hF;
        st_wdata_o = st_data_i;
      end
      default: begin
        st_be_o    = 4'h0;
        st_wdata_o = '0;
      end
    endcase
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between fetch and data access; done pulses two cycles after the request at best.
// Optional BUSY wait limit is enabled by defining MEM_ARB_TIMEOUT_EN.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int AW = 32,
  parameter int DW = 32,
`ifdef MEM_ARB_TIMEOUT_EN
  parameter int TIMEOUT = 255,
`endif
  parameter int FETCH_DEFER_MAX = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic [DW-1:0] if_rdata,
  output logic          if_done,
  input  logic [2:0]    d_memread,
  input  logic [1:0]    d_memwrite,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic [DW-1:0] d_rdata,
  output logic          d_done,
  output logic          err,
  output logic          mem_req,
  output logic          mem_we,
  output logic [3:0]    mem_be,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_ready
);

  localparam int DFW = $clog2(FETCH_DEFER_MAX + 1);

  arb_state_e    state_q, state_d;
  logic [DFW-1:0] defer_q, defer_d;
  logic          data_own_q, data_own_d;
  logic          bad_q, bad_d;
  logic [2:0]    ld_op_q, ld_op_d;
  logic [1:0]    off_q, off_d;
  logic          mem_req_q, mem_req_d;
  logic          mem_we_q, mem_we_d;
  logic [3:0]    mem_be_q, mem_be_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [DW-1:0] mem_wdata_q, mem_wdata_d;
  logic [DW-1:0] if_rdata_q, if_rdata_d;
  logic [DW-1:0] d_rdata_q, d_rdata_d;
  logic          if_done_q, if_done_d;
  logic          d_done_q, d_done_d;
  logic          err_q, err_d;
`ifdef MEM_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] cnt_q, cnt_d;
`endif

  logic          d_req, fetch_win, fin, fin_err;
  logic [31:0]   ld_data, st_wdata;
  logic [3:0]    st_be;

  mem_lane_align u_align (
    .ld_op_i    (ld_op_q),
    .ld_off_i   (off_q),
    .ld_word_i  (mem_rdata),
    .ld_data_o  (ld_data),
    .st_op_i    (d_memwrite),
    .st_off_i   (d_addr[1:0]),
    .st_data_i  (d_wdata),
    .st_be_o    (st_be),
    .st_wdata_o (st_wdata)
  );

  assign d_req     = (d_memread != MEMREAD_NONE) || (d_memwrite != MEMWRITE_NONE);
  assign fetch_win = if_req && (!d_req || (defer_q == DFW'(FETCH_DEFER_MAX)));

  always_comb begin
    state_d     = state_q;
    defer_d     = defer_q;
    data_own_d  = data_own_q;
    bad_d       = bad_q;
    ld_op_d     = ld_op_q;
    off_d       = off_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_be_d    = mem_be_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if_rdata_d  = if_rdata_q;
    d_rdata_d   = d_rdata_q;
    if_done_d   = 1'b0;
    d_done_d    = 1'b0;
    err_d       = 1'b0;
    fin         = 1'b0;
    fin_err     = 1'b0;
`ifdef MEM_ARB_TIMEOUT_EN
    cnt_d       = cnt_q;
`endif

    case (state_q)
      ARB_IDLE: begin
`ifdef MEM_ARB_TIMEOUT_EN
        cnt_d = '0;
`endif
        if (fetch_win) begin
          state_d    = ARB_BUSY;
          data_own_d = 1'b0;
          defer_d    = '0;
          ld_op_d    = MEMREAD_LW;
          off_d      = if_addr[1:0];
          bad_d      = (if_addr[1:0] != 2'b00);
          if (!bad_d) begin
            mem_req_d  = 1'b1;
            mem_we_d   = 1'b0;
            mem_be_d   = 4'hF;
            mem_addr_d = {if_addr[AW-1:2], 2'b00};
          end
        end else if (d_req) begin
          state_d    = ARB_BUSY;
          data_own_d = 1'b1;
          if (if_req) defer_d = defer_q + DFW'(1);
          ld_op_d    = d_memread;
          off_d      = d_addr[1:0];
          bad_d      = op_illegal(d_memread, d_memwrite) ||
                       op_misaligned(d_memread, d_memwrite, d_addr[1:0]);
          if (!bad_d) begin
            mem_req_d   = 1'b1;
            mem_we_d    = (d_memwrite != MEMWRITE_NONE);
            mem_be_d    = mem_we_d ? st_be : 4'hF;
            mem_wdata_d = st_wdata;
            mem_addr_d  = {d_addr[AW-1:2], 2'b00};
          end
        end
      end
      // Rejected requests spend their BUSY cycle with mem_req low so done timing stays uniform.
      ARB_BUSY: begin
        if (bad_q) begin
          fin     = 1'b1;
          fin_err = 1'b1;
        end else if (mem_ready) begin
          fin = 1'b1;
`ifdef MEM_ARB_TIMEOUT_EN
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          fin     = 1'b1;
          fin_err = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
`endif
        end
      end
      ARB_RESP: state_d = ARB_IDLE;
      default:  state_d = ARB_IDLE;
    endcase

    if (fin) begin
      state_d   = ARB_RESP;
      mem_req_d = 1'b0;
      err_d     = fin_err;
      if (data_own_q) begin
        d_done_d  = 1'b1;
        d_rdata_d = fin_err ? '0 : ld_data;
      end else begin
        if_done_d  = 1'b1;
        if_rdata_d = fin_err ? '0 : mem_rdata;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ARB_IDLE;
      defer_q     <= '0;
      data_own_q  <= 1'b0;
      bad_q       <= 1'b0;
      ld_op_q     <= '0;
      off_q       <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_be_q    <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
      if_done_q   <= 1'b0;
      d_done_q    <= 1'b0;
      err_q       <= 1'b0;
`ifdef MEM_ARB_TIMEOUT_EN
      cnt_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      defer_q     <= defer_d;
      data_own_q  <= data_own_d;
      bad_q       <= bad_d;
      ld_op_q     <= ld_op_d;
      off_q       <= off_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_be_q    <= mem_be_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_rdata_q  <= if_rdata_d;
      d_rdata_q   <= d_rdata_d;
      if_done_q   <= if_done_d;
      d_done_q    <= d_done_d;
      err_q       <= err_d;
`ifdef MEM_ARB_TIMEOUT_EN
      cnt_q       <= cnt_d;
`endif
    end
  end

  assign if_rdata  = if_rdata_q;
  assign if_done   = if_done_q;
  assign d_rdata   = d_rdata_q;
  assign d_done    = d_done_q;
  assign err       = err_q;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_be    = mem_be_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: arbitration, lane alignment, error paths and reset abort.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_done;
  logic [2:0]  d_memread;
  logic [1:0]  d_memwrite;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [31:0] d_rdata;
  logic        d_done;
  logic        err;
  logic        mem_req;
  logic        mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ready;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(
`ifdef MEM_ARB_TIMEOUT_EN
    .TIMEOUT(8),
`endif
    .FETCH_DEFER_MAX(4)
  ) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_done(if_done),
    .d_memread(d_memread), .d_memwrite(d_memwrite), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_done(d_done), .err(err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Completes the current BUSY cycle with a one-cycle mem_ready; returns in the RESP cycle.
  task automatic serve(input logic [31:0] word);
    mem_ready = 1'b1;
    mem_rdata = word;
    tick();
    mem_ready = 1'b0;
  endtask

  task automatic do_load(input string tag, input logic [2:0] rd, input logic [31:0] addr,
                         input logic [31:0] word, input logic [31:0] exp);
    d_memread = rd;
    d_addr    = addr;
    tick();
    chk({tag, " mem_req"}, {31'b0, mem_req}, 32'd1);
    chk({tag, " mem_be"}, {28'b0, mem_be}, 32'hF);
    serve(word);
    chk({tag, " d_done"}, {31'b0, d_done}, 32'd1);
    chk({tag, " d_rdata"}, d_rdata, exp);
    d_memread = 3'd0;
    tick();
  endtask

  task automatic do_store(input string tag, input logic [1:0] wr, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [3:0] exp_be,
                          input logic [31:0] exp_wdata, input logic [31:0] exp_addr);
    d_memwrite = wr;
    d_addr     = addr;
    d_wdata    = wdata;
    tick();
    chk({tag, " mem_we"}, {31'b0, mem_we}, 32'd1);
    chk({tag, " mem_be"}, {28'b0, mem_be}, {28'b0, exp_be});
    chk({tag, " mem_wdata"}, mem_wdata, exp_wdata);
    chk({tag, " mem_addr"}, mem_addr, exp_addr);
    serve(32'h0);
    chk({tag, " d_done"}, {31'b0, d_done}, 32'd1);
    chk({tag, " err"}, {31'b0, err}, 32'd0);
    d_memwrite = 2'd0;
    tick();
  endtask

  task automatic do_reject(input string tag, input logic [2:0] rd, input logic [1:0] wr,
                           input logic [31:0] addr);
    d_memread  = rd;
    d_memwrite = wr;
    d_addr     = addr;
    tick();
    chk({tag, " no mem_req c1"}, {31'b0, mem_req}, 32'd0);
    tick();
    chk({tag, " d_done c2"}, {31'b0, d_done}, 32'd1);
    chk({tag, " err c2"}, {31'b0, err}, 32'd1);
    chk({tag, " d_rdata c2"}, d_rdata, 32'h0);
    chk({tag, " no mem_req c2"}, {31'b0, mem_req}, 32'd0);
    d_memread  = 3'd0;
    d_memwrite = 2'd0;
    tick();
  endtask

  initial begin
    rst = 1'b1; if_req = 1'b0; if_addr = 32'h0;
    d_memread = 3'd0; d_memwrite = 2'd0; d_addr = 32'h0; d_wdata = 32'h0;
    mem_rdata = 32'h0; mem_ready = 1'b0;
    tick(); tick();
    chk("reset mem_req", {31'b0, mem_req}, 32'd0);
    chk("reset if_done", {31'b0, if_done}, 32'd0);
    chk("reset d_done", {31'b0, d_done}, 32'd0);
    chk("reset err", {31'b0, err}, 32'd0);
    chk("reset mem_be", {28'b0, mem_be}, 32'd0);
    chk("reset mem_addr", mem_addr, 32'h0);
    chk("reset if_rdata", if_rdata, 32'h0);
    rst = 1'b0;
    tick();

    // Plain fetch at minimum latency.
    if_req = 1'b1; if_addr = 32'h100;
    tick();
    chk("fetch mem_req c1", {31'b0, mem_req}, 32'd1);
    chk("fetch mem_addr", mem_addr, 32'h100);
    chk("fetch mem_we", {31'b0, mem_we}, 32'd0);
    chk("fetch mem_be", {28'b0, mem_be}, 32'hF);
    serve(32'h00500093);
    chk("fetch if_done c2", {31'b0, if_done}, 32'd1);
    chk("fetch if_rdata", if_rdata, 32'h00500093);
    chk("fetch err", {31'b0, err}, 32'd0);
    chk("fetch mem_req c2", {31'b0, mem_req}, 32'd0);
    if_req = 1'b0;
    tick();
    chk("fetch if_done c3", {31'b0, if_done}, 32'd0);

    // Data beats fetch four times, then fetch is forced through.
    if_req = 1'b1; if_addr = 32'h100;
    d_memread = 3'd3; d_addr = 32'h200;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("arb data wins addr", mem_addr, 32'h200);
      serve(32'h11110000 + 32'(i));
      chk("arb d_done", {31'b0, d_done}, 32'd1);
      chk("arb if_done low", {31'b0, if_done}, 32'd0);
      chk("arb d_rdata", d_rdata, 32'h11110000 + 32'(i));
      tick();
    end
    tick();
    chk("arb fetch forced addr", mem_addr, 32'h100);
    serve(32'hCAFEF00D);
    chk("arb fetch if_done", {31'b0, if_done}, 32'd1);
    chk("arb fetch d_done low", {31'b0, d_done}, 32'd0);
    chk("arb fetch if_rdata", if_rdata, 32'hCAFEF00D);
    if_req = 1'b0; d_memread = 3'd0;
    tick();

    // Load lane extraction and extension.
    do_load("LB 0x203", 3'd1, 32'h203, 32'h80112233, 32'hFFFFFF80);
    do_load("LBU 0x203", 3'd4, 32'h203, 32'h80112233, 32'h00000080);
    do_load("LHU 0x202", 3'd5, 32'h202, 32'h80112233, 32'h00008011);
    do_load("LH 0x202", 3'd2, 32'h202, 32'h80112233, 32'hFFFF8011);
    do_load("LB 0x200", 3'd1, 32'h200, 32'h80112233, 32'h00000033);

    // Store lane generation.
    do_store("SH 0x206", 2'd2, 32'h206, 32'h0000BEEF, 4'hC, 32'hBEEFBEEF, 32'h204);
    do_store("SB 0x201", 2'd1, 32'h201, 32'h000000A5, 4'h2, 32'hA5A5A5A5, 32'h200);
    do_store("SW 0x208", 2'd3, 32'h208, 32'h12345678, 4'hF, 32'h12345678, 32'h208);

    // Rejected requests never touch memory.
    do_reject("LW misaligned", 3'd3, 2'd0, 32'h201);
    do_reject("illegal rd+wr", 3'd3, 2'd3, 32'h200);
    do_reject("SH misaligned", 3'd0, 2'd2, 32'h205);

    // Reset while waiting on memory aborts without a done.
    d_memread = 3'd3; d_addr = 32'h300;
    tick();
    chk("rst-abort mem_req c1", {31'b0, mem_req}, 32'd1);
    tick();
    chk("rst-abort mem_req held", {31'b0, mem_req}, 32'd1);
    chk("rst-abort mem_addr held", mem_addr, 32'h300);
    rst = 1'b1;
    tick();
    chk("rst-abort mem_req dropped", {31'b0, mem_req}, 32'd0);
    chk("rst-abort no d_done", {31'b0, d_done}, 32'd0);
    rst = 1'b0; d_memread = 3'd0;
    tick();
    chk("rst-abort no late d_done", {31'b0, d_done}, 32'd0);
    chk("rst-abort no err", {31'b0, err}, 32'd0);

`ifdef MEM_ARB_TIMEOUT_EN
    d_memread = 3'd3; d_addr = 32'h400;
    tick();
    chk("timeout mem_req c1", {31'b0, mem_req}, 32'd1);
    repeat (7) tick();
    chk("timeout mem_req c8", {31'b0, mem_req}, 32'd1);
    tick();
    chk("timeout d_done", {31'b0, d_done}, 32'd1);
    chk("timeout err", {31'b0, err}, 32'd1);
    chk("timeout d_rdata", d_rdata, 32'h0);
    chk("timeout mem_req dropped", {31'b0, mem_req}, 32'd0);
    d_memread = 3'd0;
    tick();
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, required finish before 200000");
    $fatal(1);
  end

endmodule
